// File: rtl/jpeg_mcu_pkg.sv
// Shared types and constants for the JPEG MCU raster writer: FSM states,
// colour-conversion coefficients and block geometry.
package jpeg_mcu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int CC_CR_R = 1436;
   localparam int CC_CB_G = 352;
   localparam int CC_CR_G = 731;
   localparam int CC_CB_B = 1815;

   localparam int BLK_DIM     = 8;
   localparam int BLK_SAMPLES = 64;
   localparam int MAX_BLKS    = 6;

   // Number of luma blocks (H*V) for H,V in {1,2}; Cb and Cr follow them.
   function automatic logic [2:0] luma_blocks(input logic h2, input logic v2);
      logic [2:0] n;
      case ({h2, v2})
         2'b00:   n = 3'd1;
         2'b11:   n = 3'd4;
         default: n = 3'd2;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ycc_to_rgb.sv
// Combinational fixed-point YCbCr to RGB conversion with 8-bit saturation.
module ycc_to_rgb
   import jpeg_mcu_pkg::*;
#(
   parameter int COEF_W    = 16,
   parameter int FRAC_BITS = 10
) (
   input  logic signed [COEF_W-1:0] y,
   input  logic signed [COEF_W-1:0] cb,
   input  logic signed [COEF_W-1:0] cr,
   output logic [7:0]               r,
   output logic [7:0]               g,
   output logic [7:0]               b
);

   logic signed [31:0] y32, cb32, cr32, ys;
   logic signed [31:0] r_fx, g_fx, b_fx;

   function automatic logic [7:0] clamp(input logic signed [31:0] v);
      logic [7:0] res;
      if (v < 0)
         res = 8'd0;
      else if (v > (32'sd255 <<< FRAC_BITS))
         res = 8'hFF;
      else
         res = v[FRAC_BITS+7:FRAC_BITS];
      return res;
   endfunction

   assign y32  = 32'(y);
   assign cb32 = 32'(cb);
   assign cr32 = 32'(cr);
   assign ys   = (y32 + 32'sd128) <<< FRAC_BITS;

   assign r_fx = ys + CC_CR_R * cr32;
   assign g_fx = ys - CC_CB_G * cb32 - CC_CR_G * cr32;
   assign b_fx = ys + CC_CB_B * cb32;

   assign r = clamp(r_fx);
   assign g = clamp(g_fx);
   assign b = clamp(b_fx);

endmodule

// File: rtl/mcu_raster_writer.sv
// Buffers one MCU of IDCT blocks, then streams cropped RGB pixels with
// absolute image coordinates over a valid/ready interface.
module mcu_raster_writer
   import jpeg_mcu_pkg::*;
#(
   parameter int COEF_W    = 16,
   parameter int DIM_W     = 16,
   parameter int FRAC_BITS = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [1:0]                    y_h_samp,
   input  logic [1:0]                    y_v_samp,
   input  logic [DIM_W-1:0]              img_width,
   input  logic [DIM_W-1:0]              img_height,
   input  logic [BLK_SAMPLES*COEF_W-1:0] blk_data,
   input  logic                          blk_valid,
   output logic                          blk_ready,
   output logic [7:0]                    pix_r,
   output logic [7:0]                    pix_g,
   output logic [7:0]                    pix_b,
   output logic [DIM_W-1:0]              pix_x,
   output logic [DIM_W-1:0]              pix_y,
   output logic                          pix_valid,
   input  logic                          pix_ready,
   output logic                          pix_last,
   output logic                          image_done,
   output logic                          cfg_err
);

   // Wide enough for an MCU base plus in-MCU offset past the image edge.
   localparam int PW = DIM_W + 5;

   state_e                        state;
   logic                          h2, v2;
   logic [DIM_W-1:0]              width, height, mcus_x, mcus_y, mcu_x, mcu_y;
   logic [2:0]                    blk_idx;
   logic [3:0]                    row, col;
   logic [BLK_SAMPLES*COEF_W-1:0] blk_buf [MAX_BLKS];

   logic             cfg_ok, in_h2, in_v2, start_go;
   logic [DIM_W:0]   w_round, h_round;
   logic [DIM_W-1:0] in_mcus_x, in_mcus_y;

   logic [PW-1:0] pos_x, pos_y;
   logic          in_img, can_load, emit_load, emit_step, blk_fire;
   logic          last_col, last_row, last_mcu_x, last_mcu_y, at_last_pix;
   logic [2:0]    n_luma, lblk;
   logic [5:0]    lidx, cidx;

   logic signed [COEF_W-1:0] y_s, cb_s, cr_s;
   logic [7:0]               cv_r, cv_g, cv_b;

   // Configuration decode straight from the inputs, used only on the start cycle.
   always_comb begin
      in_h2     = (y_h_samp == 2'd2);
      in_v2     = (y_v_samp == 2'd2);
      cfg_ok    = (y_h_samp == 2'd1 || in_h2) && (y_v_samp == 2'd1 || in_v2);
      w_round   = {1'b0, img_width}  + (in_h2 ? (DIM_W+1)'(15) : (DIM_W+1)'(7));
      h_round   = {1'b0, img_height} + (in_v2 ? (DIM_W+1)'(15) : (DIM_W+1)'(7));
      in_mcus_x = DIM_W'(w_round >> (in_h2 ? 3'd4 : 3'd3));
      in_mcus_y = DIM_W'(h_round >> (in_v2 ? 3'd4 : 3'd3));
      start_go  = start && (state == ST_IDLE || (state == ST_DONE && image_done));
   end

   assign blk_ready = (state == ST_LOAD);
   assign blk_fire  = blk_valid && blk_ready;

   always_comb begin
      pos_x       = (PW'(mcu_x) << (h2 ? 3'd4 : 3'd3)) + PW'(col);
      pos_y       = (PW'(mcu_y) << (v2 ? 3'd4 : 3'd3)) + PW'(row);
      in_img      = (pos_x < PW'(width)) && (pos_y < PW'(height));
      at_last_pix = (pos_x == PW'(width - DIM_W'(1))) && (pos_y == PW'(height - DIM_W'(1)));
      last_col    = (col == (h2 ? 4'd15 : 4'd7));
      last_row    = (row == (v2 ? 4'd15 : 4'd7));
      last_mcu_x  = (mcu_x == mcus_x - DIM_W'(1));
      last_mcu_y  = (mcu_y == mcus_y - DIM_W'(1));
      can_load    = !pix_valid || pix_ready;
      emit_load   = (state == ST_EMIT) && in_img && can_load;
      emit_step   = (state == ST_EMIT) && (!in_img || can_load);
   end

   // Luma comes from the 8x8 tile under the position; chroma is upsampled by
   // nearest neighbour from the single Cb/Cr block.
   always_comb begin
      n_luma = luma_blocks(h2, v2);
      lblk   = h2 ? {1'b0, row[3], col[3]} : {2'b00, row[3]};
      lidx   = {row[2:0], col[2:0]};
      cidx   = {(v2 ? row[3:1] : row[2:0]), (h2 ? col[3:1] : col[2:0])};
      y_s    = blk_buf[lblk][lidx*COEF_W +: COEF_W];
      cb_s   = blk_buf[n_luma][cidx*COEF_W +: COEF_W];
      cr_s   = blk_buf[n_luma + 3'd1][cidx*COEF_W +: COEF_W];
   end

   ycc_to_rgb #(
      .COEF_W    (COEF_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_ycc_to_rgb (
      .y  (y_s),
      .cb (cb_s),
      .cr (cr_s),
      .r  (cv_r),
      .g  (cv_g),
      .b  (cv_b)
   );

   // NOTE: the block buffer has no reset; blk_idx restarting at 0 is what
   // discards stale contents, and leaving the array unreset keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (blk_fire)
         blk_buf[blk_idx] <= blk_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         h2         <= 1'b0;
         v2         <= 1'b0;
         width      <= '0;
         height     <= '0;
         mcus_x     <= '0;
         mcus_y     <= '0;
         mcu_x      <= '0;
         mcu_y      <= '0;
         blk_idx    <= '0;
         row        <= '0;
         col        <= '0;
         pix_valid  <= 1'b0;
         pix_last   <= 1'b0;
         pix_r      <= '0;
         pix_g      <= '0;
         pix_b      <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         image_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         // NOTE: the drain below is overridden by a same-cycle reload further
         // down; with non-blocking assignments the last one wins.
         if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
         end

         if (start_go) begin
            h2         <= in_h2;
            v2         <= in_v2;
            width      <= img_width;
            height     <= img_height;
            mcus_x     <= in_mcus_x;
            mcus_y     <= in_mcus_y;
            mcu_x      <= '0;
            mcu_y      <= '0;
            blk_idx    <= '0;
            row        <= '0;
            col        <= '0;
            cfg_err    <= !cfg_ok;
            image_done <= 1'b0;
            state      <= cfg_ok ? ST_LOAD : ST_IDLE;
         end else begin
            case (state)
               ST_LOAD: begin
                  if (blk_fire) begin
                     if (blk_idx == n_luma + 3'd1) begin
                        blk_idx <= '0;
                        state   <= ST_EMIT;
                     end else begin
                        blk_idx <= blk_idx + 3'd1;
                     end
                  end
               end
               ST_EMIT: begin
                  if (emit_load) begin
                     pix_valid <= 1'b1;
                     pix_last  <= at_last_pix;
                     pix_r     <= cv_r;
                     pix_g     <= cv_g;
                     pix_b     <= cv_b;
                     pix_x     <= pos_x[DIM_W-1:0];
                     pix_y     <= pos_y[DIM_W-1:0];
                  end
                  if (emit_step) begin
                     if (!last_col) begin
                        col <= col + 4'd1;
                     end else begin
                        col <= '0;
                        if (!last_row) begin
                           row <= row + 4'd1;
                        end else begin
                           row <= '0;
                           if (!last_mcu_x) begin
                              mcu_x <= mcu_x + DIM_W'(1);
                              state <= ST_LOAD;
                           end else begin
                              mcu_x <= '0;
                              if (last_mcu_y) begin
                                 state <= ST_DONE;
                              end else begin
                                 mcu_y <= mcu_y + DIM_W'(1);
                                 state <= ST_LOAD;
                              end
                           end
                        end
                     end
                  end
               end
               ST_DONE: begin
                  // The final pixel may still sit in the output register.
                  if (can_load)
                     image_done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mcu_raster_writer.sv
// Self-checking bench for mcu_raster_writer: config table, directed images and
// randomized images compared against an image-level reference model.
module tb_mcu_raster_writer;

   localparam int COEF_W = 16;
   localparam int DIM_W  = 16;
   localparam int FRAC   = 10;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   start = 1'b0;
   logic [1:0]             y_h_samp = 2'd1;
   logic [1:0]             y_v_samp = 2'd1;
   logic [DIM_W-1:0]       img_width = 16'd8;
   logic [DIM_W-1:0]       img_height = 16'd8;
   logic [64*COEF_W-1:0]   blk_data = '0;
   logic                   blk_valid = 1'b0;
   logic                   blk_ready;
   logic [7:0]             pix_r, pix_g, pix_b;
   logic [DIM_W-1:0]       pix_x, pix_y;
   logic                   pix_valid;
   logic                   pix_ready = 1'b1;
   logic                   pix_last, image_done, cfg_err;

   mcu_raster_writer #(
      .COEF_W    (COEF_W),
      .DIM_W     (DIM_W),
      .FRAC_BITS (FRAC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .y_h_samp   (y_h_samp),
      .y_v_samp   (y_v_samp),
      .img_width  (img_width),
      .img_height (img_height),
      .blk_data   (blk_data),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .pix_r      (pix_r),
      .pix_g      (pix_g),
      .pix_b      (pix_b),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_last   (pix_last),
      .image_done (image_done),
      .cfg_err    (cfg_err)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int r;
      int g;
      int b;
      bit last;
   } pix_t;

   typedef struct {
      int h;
      int v;
      bit exp_err;
      bit exp_ready;
   } cfg_vec_t;

   pix_t       exp_q[$];
   cfg_vec_t   cfg_tab[8];
   int         cur_blk[6][64];
   logic [7:0] cap_r[64][64];
   logic [7:0] cap_g[64][64];
   logic [7:0] cap_b[64][64];

   int n_checks = 0;
   int n_fail   = 0;
   int pix_count = 0;
   int ready_mode = 0;
   bit exp_uncropped = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int clamp8(input int v);
      if (v < 0) return 0;
      if (v > (255 << FRAC)) return 255;
      return v >>> FRAC;
   endfunction

   function automatic logic [56:0] pack_pix(input pix_t p);
      return {16'(p.x), 16'(p.y), 8'(p.r), 8'(p.g), 8'(p.b), p.last};
   endfunction

   // Reference: expected pixels of one MCU, from image geometry and the sampling rules.
   task automatic model_mcu(input int h, input int v, input int w, input int hh,
                            input int mx, input int my);
      pix_t p;
      int   yv, cb, cr, c, ys;
      for (int row = 0; row < 8*v; row++) begin
         for (int col = 0; col < 8*h; col++) begin
            p.x = mx*8*h + col;
            p.y = my*8*v + row;
            if (p.x < w && p.y < hh) begin
               yv = cur_blk[(row/8)*h + col/8][(row%8)*8 + col%8];
               c  = (row/v)*8 + col/h;
               cb = cur_blk[h*v][c];
               cr = cur_blk[h*v+1][c];
               ys = (yv + 128) * (1 << FRAC);
               p.r = clamp8(ys + 1436*cr);
               p.g = clamp8(ys - 352*cb - 731*cr);
               p.b = clamp8(ys + 1815*cb);
               p.last = (p.x == w-1) && (p.y == hh-1);
               exp_q.push_back(p);
            end
         end
      end
   endtask

   task automatic gen_blocks(input int h, input int v, input int pat);
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < 64; k++) begin
            case (pat)
               0:       cur_blk[b][k] = 0;
               1:       cur_blk[b][k] = (b < h*v) ? 10*b : 0;
               default: cur_blk[b][k] = (b < h*v) ? int'($urandom_range(0, 600)) - 300
                                                  : int'($urandom_range(0, 400)) - 200;
            endcase
         end
      end
      if (pat == 1) cur_blk[h*v+1][0] = 127;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send_block(input int b);
      int n;
      for (int k = 0; k < 64; k++) blk_data[k*COEF_W +: COEF_W] = 16'(cur_blk[b][k]);
      blk_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!blk_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!blk_ready) check($sformatf("blk_accept_timeout_%0d", b), 64'(blk_ready), 64'(1));
      @(posedge clk);
      #1 blk_valid = 1'b0;
   endtask

   task automatic pulse_start(input int h, input int v, input int w, input int hh);
      y_h_samp   = 2'(h);
      y_v_samp   = 2'(v);
      img_width  = 16'(w);
      img_height = 16'(hh);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_image(input int h, input int v, input int w, input int hh,
                            input int pat, input int rmode);
      int mxn, myn, n;
      ready_mode    = rmode;
      exp_uncropped = (w % (8*h) == 0) && (hh % (8*v) == 0);
      pix_count     = 0;
      pulse_start(h, v, w, hh);
      mxn = (w + 8*h - 1) / (8*h);
      myn = (hh + 8*v - 1) / (8*v);
      for (int my = 0; my < myn; my++) begin
         for (int mx = 0; mx < mxn; mx++) begin
            gen_blocks(h, v, pat);
            model_mcu(h, v, w, hh, mx, my);
            for (int b = 0; b < h*v + 2; b++) send_block(b);
         end
      end
      n = 0;
      while (!image_done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check($sformatf("image_done_%0dx%0d", w, hh), 64'(image_done), 64'(1));
      check($sformatf("pixel_count_%0dx%0d", w, hh), 64'(pix_count), 64'(w*hh));
      check("queue_drained", 64'(exp_q.size()), 64'(0));
      check("blk_ready_in_done", 64'(blk_ready), 64'(0));
   endtask

   initial begin
      logic [56:0] act_vec, held_vec;
      bit          hold_valid, last_prev;
      pix_t        e;

      cfg_tab[0] = '{3, 1, 1'b1, 1'b0};
      cfg_tab[1] = '{1, 1, 1'b0, 1'b1};
      cfg_tab[2] = '{0, 2, 1'b1, 1'b0};
      cfg_tab[3] = '{2, 2, 1'b0, 1'b1};
      cfg_tab[4] = '{1, 3, 1'b1, 1'b0};
      cfg_tab[5] = '{2, 1, 1'b0, 1'b1};
      cfg_tab[6] = '{2, 0, 1'b1, 1'b0};
      cfg_tab[7] = '{1, 2, 1'b0, 1'b1};

      fork
         // Output monitor: ordering, hold stability and image_done timing.
         begin
            hold_valid = 1'b0;
            last_prev  = 1'b0;
            forever begin
               @(negedge clk);
               if (rst) begin
                  hold_valid = 1'b0;
                  last_prev  = 1'b0;
               end else begin
                  act_vec = {pix_x, pix_y, pix_r, pix_g, pix_b, pix_last};
                  if (hold_valid)
                     check("hold_stable", {6'b0, pix_valid, act_vec}, {6'b0, 1'b1, held_vec});
                  if (last_prev)
                     check("image_done_after_last", 64'(image_done), 64'(1));
                  last_prev  = 1'b0;
                  hold_valid = pix_valid && !pix_ready;
                  held_vec   = act_vec;
                  if (pix_valid && pix_ready) begin
                     pix_count++;
                     if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pixel: got x=%0d y=%0d, required no pixel", pix_x, pix_y);
                     end else begin
                        e = exp_q.pop_front();
                        check($sformatf("pixel_%0d_%0d", e.x, e.y), 64'(act_vec), 64'(pack_pix(e)));
                     end
                     if (pix_x < 64 && pix_y < 64) begin
                        cap_r[int'(pix_x)][int'(pix_y)] = pix_r;
                        cap_g[int'(pix_x)][int'(pix_y)] = pix_g;
                        cap_b[int'(pix_x)][int'(pix_y)] = pix_b;
                     end
                     if (pix_last && exp_uncropped) begin
                        check("image_done_before_last", 64'(image_done), 64'(0));
                        last_prev = 1'b1;
                     end
                  end
               end
            end
         end
         // Downstream ready pattern.
         forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
               0:       pix_ready = 1'b1;
               1:       pix_ready = ~pix_ready;
               default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
         end
      join_none

      // Reset state.
      @(posedge clk);
      @(negedge clk);
      check("reset_outputs",
            64'({blk_ready, pix_valid, pix_last, image_done, cfg_err, pix_r, pix_g, pix_b, pix_x, pix_y}),
            64'(0));
      do_reset();

      // Config table: illegal sampling stays in IDLE, legal goes to LOAD.
      for (int i = 0; i < 8; i++) begin
         pulse_start(cfg_tab[i].h, cfg_tab[i].v, 16, 16);
         @(negedge clk);
         check($sformatf("cfg_err_vec%0d", i), 64'(cfg_err), 64'(cfg_tab[i].exp_err));
         check($sformatf("blk_ready_vec%0d", i), 64'(blk_ready), 64'(cfg_tab[i].exp_ready));
         if (cfg_tab[i].exp_ready) begin
            pulse_start(3, 1, 16, 16);
            @(negedge clk);
            check("start_ignored_in_load", 64'({cfg_err, blk_ready}), 64'(2'b01));
            do_reset();
         end
      end

      // 8x8 4:4:4 zeros: mid-grey everywhere.
      run_image(1, 1, 8, 8, 0, 0);
      check("gray_00", 64'({cap_r[0][0], cap_g[0][0], cap_b[0][0]}), 64'(24'h808080));
      check("gray_77", 64'({cap_r[7][7], cap_g[7][7], cap_b[7][7]}), 64'(24'h808080));

      // Same image with pix_ready toggling every cycle.
      run_image(1, 1, 8, 8, 0, 1);

      // 16x16 4:2:0 stepped luma, one saturating Cr sample.
      run_image(2, 2, 16, 16, 1, 0);
      check("r_00_clamped", 64'(cap_r[0][0]), 64'(255));
      check("gray_80", 64'({cap_r[8][0], cap_g[8][0], cap_b[8][0]}), 64'({8'd138, 8'd138, 8'd138}));
      check("gray_88", 64'({cap_r[8][8], cap_g[8][8], cap_b[8][8]}), 64'({8'd158, 8'd158, 8'd158}));

      // Extra blocks offered in DONE are never taken.
      blk_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_blk_in_done", 64'({blk_ready, image_done}), 64'(2'b01));
      end
      @(posedge clk);
      #1 blk_valid = 1'b0;

      // Randomized images including cropped edges and a single-pixel image.
      run_image(2, 1, 20, 10, 2, 2);
      run_image(1, 2, 13, 21, 2, 2);
      run_image(2, 2, 1, 1, 2, 0);
      run_image(2, 2, 40, 24, 2, 2);

      // Reset after two of six 4:2:0 blocks, then a fresh image.
      pulse_start(2, 2, 16, 16);
      gen_blocks(2, 2, 2);
      send_block(0);
      send_block(1);
      rst = 1'b1;
      blk_valid = 1'b1;
      @(posedge clk);
      #1 blk_valid = 1'b0;
      @(negedge clk);
      check("mid_mcu_reset_outputs",
            64'({blk_ready, pix_valid, pix_last, image_done, cfg_err, pix_r, pix_g, pix_b, pix_x, pix_y}),
            64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      run_image(1, 1, 8, 8, 2, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
